alu_seq_divider: RTL
====================

Name: alu_seq_divider

Overview:
- Multi-cycle unsigned restoring divider for the ALU's divide and modulus operations.
- Sits beside the adder/subtractor and multiplier.
- Consumes the same 16-bit operands and produces a 32-bit result word plus a divide-by-zero flag.
- The result word feeds the ALU result-select multiplexer.
- Start/ready/done handshake lets the ALU control sequencer wait out the iterative operation.

Parameters:
- N, 16, operand width in bits; quotient and remainder are N bits, result word is 2N bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only while ready=1.
- op_mod  in  1  0 = divide (result is quotient), 1 = modulus (result is remainder).
- clr  in  1  synchronous clear: abort any operation, zero all outputs.
- a  in  N  dividend, unsigned.
- b  in  N  divisor, unsigned.
- ready  out  1  high when a start will be accepted.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when result/quot/rem/dbz become valid.
- quot  out  N  quotient, held until next accepted start, clr or reset.
- rem  out  N  remainder, same hold rule.
- result  out  2N  {N'b0, quot} when op_mod=0, {N'b0, rem} when op_mod=1; op_mod is latched at start.
- dbz  out  1  divide-by-zero error, same hold rule.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; quot, rem, result, dbz, done, busy = 0; ready=1.
  - Iteration counter and working registers cleared.
- States:
  - IDLE: ready=1, busy=0, done=0.
  - RUN: ready=0, busy=1.
  - DONE: ready=1, busy=0, done=1 for exactly this one cycle.
- Transitions:
  - IDLE or DONE with start=1:
    - Latch a, b, op_mod. Clear dbz.
    - If b=0: go to DONE next cycle. quot=0, rem=0, result=0, dbz=1. Latency 1.
    - Else: load working quotient Q=a, partial remainder R=0 ((N+1)-bit), counter=N-1, go to RUN.
  - RUN, every cycle:
    - T={R[N-1:0], Q[N-1]} minus {1'b0,b}.
    - If T is non-negative (MSB=0): R=T, Q={Q[N-2:0],1}. Else R={R[N-1:0],Q[N-1]}, Q={Q[N-2:0],0}.
    - counter decrements.
    - When counter=0 this cycle: go to DONE, and load quot/rem/result from the final-iteration values in the same edge.
  - DONE without start: go to IDLE. DONE with start: handled as from IDLE, i.e. back-to-back operation is allowed.
- Latency: start accepted at edge k gives done high in the cycle after edge k+N; done is high in the 17th cycle after start for N=16.
- Outputs quot/rem/result/dbz change only at completion (into DONE), clr or reset. They are stable in IDLE and during RUN, where they keep the previous operation's values.
- start while busy=1: ignored, no effect on the current operation.
- clr (synchronous, highest priority after reset): any state goes to IDLE next edge; outputs and dbz are zeroed; a start in the same cycle is ignored.
- Reset mid-RUN: immediate abort to reset values; no done pulse.
- Operand changes on a/b after acceptance have no effect.
- Boundary values:
  - a < b: quot=0, rem=a.
  - a=0, b≠0: quot=0, rem=0, full N-cycle latency (no early exit).
  - b=1: quot=a, rem=0.

Decomposition:
- Shared ALU package holds:
  - width constant N=16.
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Op-select encodings used by the ALU result mux, including the divide and modulus codes this block serves.
- One natural sub-module, alu_div_step: combinational single iteration.
  - Inputs: R, Q, b.
  - Outputs: next R, next Q.
  - Built on the team's existing ripple add/subtract style.
- The FSM, counter and output registers live in the top module.

Test Plan:
- a=100, b=7, op_mod=0, start pulse → ready low for 16 cycles, done pulse 17 cycles after start; quot=14, rem=2, result=32'd14, dbz=0.
- a=16'hFFFF, b=16'h0010, op_mod=1 → quot=16'h0FFF, rem=16'h000F, result=32'h0000000F; then immediate second start in DONE cycle with a=5, b=9 → quot=0, rem=5, 17 cycles later.
- a=1234, b=0 → done 1 cycle after start, dbz=1, quot=rem=result=0; a following valid divide clears dbz.
- Start accepted with a=1000, b=3; at cycle 5 drive start with a=9, b=9 → ignored; final quot=333, rem=1.
- clr at cycle 8 of a run → IDLE, all outputs 0, no done pulse; rst_n low at cycle 6 of another run → asynchronous return to reset values, ready=1.
- Random sweep of 1000 operand pairs with b≠0 → quot=a/b, rem=a%b, done exactly once per accepted start.

Source files
------------

// File: rtl/alu_seq_divider_pkg.sv
// alu_seq_divider_pkg: shared ALU width, divider state encoding and result-mux op codes
package alu_seq_divider_pkg;
  localparam int N = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_MOD = 3'd4
  } alu_op_e;
  function automatic logic is_div_op(alu_op_e op);
    return op == OP_DIV || op == OP_MOD;
  endfunction
endpackage

// File: rtl/alu_seq_divider_if.sv
// alu_seq_divider_if: start/ready/done handshake, operands and results of the divider
interface alu_seq_divider_if;
  import alu_seq_divider_pkg::*;
  logic start, op_mod, clr, ready, busy, done, dbz;
  logic [N-1:0] a, b, quot, rem;
  logic [2*N-1:0] result;
  modport master(output start, op_mod, clr, a, b, input ready, busy, done, quot, rem, result, dbz);
  modport slave(input start, op_mod, clr, a, b, output ready, busy, done, quot, rem, result, dbz);
endinterface

// File: rtl/alu_seq_divider_step.sv
// alu_div_step: one restoring-division iteration built on a ripple subtractor
module alu_div_step
  import alu_seq_divider_pkg::*;
(
  input  logic [N-1:0] r_i,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] r_o,
  output logic [N-1:0] q_o
);
  logic [N:0] x, y, t;
  logic [N:0] c;
  assign x = {r_i, q_i[N-1]};
  assign y = ~{1'b0, b_i};
  assign c[0] = 1'b1;
  for (genvar i = 0; i <= N; i++) begin : g_rip
    assign t[i] = x[i] ^ y[i] ^ c[i];
    if (i < N) begin : g_c
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end
  // remainder stays below b, so the kept value always fits in N bits
  assign r_o = t[N] ? x[N-1:0] : t[N-1:0];
  assign q_o = {q_i[N-2:0], ~t[N]};
endmodule

// File: rtl/alu_seq_divider.sv
// alu_seq_divider: multi-cycle unsigned restoring divider for ALU divide/modulus
module alu_seq_divider
  import alu_seq_divider_pkg::*;
(
  input logic clk,
  input logic rst_n,
  alu_seq_divider_if.slave bus
);
  localparam int CW = $clog2(N);
  state_e state_q;
  logic [N-1:0] q_q, r_q, b_q, q_d, r_d, quot_q, rem_q;
  logic [CW-1:0] cnt_q;
  logic [2*N-1:0] result_q;
  logic op_q, done_q, busy_q, ready_q, dbz_q;
  alu_div_step u_step (.r_i(r_q), .q_i(q_q), .b_i(b_q), .r_o(r_d), .q_o(q_d));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      {q_q, r_q, b_q, cnt_q, op_q} <= '0;
      {quot_q, rem_q, result_q, dbz_q, done_q, busy_q} <= '0;
      ready_q  <= 1'b1;
    end else if (bus.clr) begin
      state_q  <= IDLE;
      {q_q, r_q, b_q, cnt_q, op_q} <= '0;
      {quot_q, rem_q, result_q, dbz_q, done_q, busy_q} <= '0;
      ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (ready_q && bus.start) begin
        b_q   <= bus.b;
        op_q  <= bus.op_mod;
        dbz_q <= bus.b == '0;
        if (bus.b == '0) begin
          state_q  <= DONE;
          quot_q   <= '0;
          rem_q    <= '0;
          result_q <= '0;
          done_q   <= 1'b1;
        end else begin
          state_q <= RUN;
          q_q     <= bus.a;
          r_q     <= '0;
          cnt_q   <= CW'(N - 1);
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
      end else if (state_q == RUN) begin
        q_q   <= q_d;
        r_q   <= r_d;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_q  <= DONE;
          quot_q   <= q_d;
          rem_q    <= r_d;
          result_q <= {{N{1'b0}}, op_q ? r_d : q_d};
          done_q   <= 1'b1;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
      end else if (state_q == DONE) begin
        state_q <= IDLE;
      end
    end
  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.quot   = quot_q;
  assign bus.rem    = rem_q;
  assign bus.result = result_q;
  assign bus.dbz    = dbz_q;
endmodule
